// File: rtl/if_prefetch_queue.sv
// ----------------------------------------------------------------------------
// if_prefetch_queue
//   Instruction prefetch unit that sits in front of the decode pipeline
//   register. It generates sequential fetch PCs, issues requests to a
//   variable-latency in-order instruction memory, and buffers up to DEPTH
//   {pc, instr} pairs in program order. An ex-stage redirect flushes the
//   queue and retargets fetch. Responses that are still in flight at a
//   redirect are counted and discarded on arrival.
//
//   Optional feature macro: IF_PREFETCH_PERF_EN
//     When defined, the block adds two saturating 32-bit performance counters
//     (redirect cycles and bubble cycles). They have no functional effect.
//
// Ports
//   clk                in   clock, all logic on posedge
//   rst                in   synchronous active-high reset
//   imem_req_valid     out  fetch request valid
//   imem_req_ready     in   IMEM accepts request
//   imem_req_addr      out  word-aligned fetch byte address
//   imem_rsp_valid     in   in-order response valid (never back-pressured)
//   imem_rsp_data      in   fetched instruction
//   br_taken           in   redirect from ex stage
//   br_target          in   redirect address (bits [1:0] ignored)
//   stall              in   decode hazard stall, holds the head entry
//   inst_valid         out  head entry holds valid data
//   inst               out  head instruction
//   inst_pc            out  head PC
//   perf_redirect_cnt  out  (IF_PREFETCH_PERF_EN) redirect cycle count
//   perf_bubble_cnt    out  (IF_PREFETCH_PERF_EN) empty-head cycle count
// ----------------------------------------------------------------------------
module if_prefetch_queue #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
`ifdef IF_PREFETCH_PERF_EN
  output logic [31:0]           perf_redirect_cnt,
  output logic [31:0]           perf_bubble_cnt,
`endif
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  br_taken,
  input  logic [ADDR_WIDTH-1:0] br_target,
  input  logic                  stall,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  localparam int unsigned PW = $clog2(DEPTH);

  // Three pointers walk the ring in order: head <= fill <= tail.
  // [head, fill) are filled entries, [fill, tail) are in flight.
  logic [PW:0]           r_head;
  logic [PW:0]           r_fill;
  logic [PW:0]           r_tail;
  logic [PW:0]           r_drop_cnt;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];

  logic                  w_full;
  logic                  w_head_valid;
  logic [PW:0]           w_unfilled;
  logic                  w_req_fire;
  logic                  w_rsp_drop;
  logic                  w_rsp_write;
  logic                  w_deq;
  logic [ADDR_WIDTH-1:0] w_br_pc;

  // Full when the pointers alias on the low bits but differ in the wrap bit.
  // Uses registered head only, so a dequeue frees a slot one cycle later.
  assign w_full       = (r_head[PW] != r_tail[PW]) && (r_head[PW-1:0] == r_tail[PW-1:0]);
  assign w_head_valid = (r_head != r_fill);
  assign w_unfilled   = r_tail - r_fill;
  assign w_br_pc      = br_target & ~(ADDR_WIDTH'(3));

  assign imem_req_valid = !rst && !br_taken && !w_full;
  assign imem_req_addr  = r_fetch_pc;

  assign w_req_fire  = imem_req_valid && imem_req_ready;
  assign w_rsp_drop  = imem_rsp_valid && (r_drop_cnt != {(PW+1){1'b0}});
  // A response arriving in a redirect cycle belongs to a flushed slot.
  assign w_rsp_write = imem_rsp_valid && (r_drop_cnt == {(PW+1){1'b0}}) && !br_taken && !rst;
  assign w_deq       = w_head_valid && !stall && !br_taken;

  assign inst_valid = w_head_valid && !rst;
  assign inst       = inst_valid ? r_data_mem[r_head[PW-1:0]] : {DATA_WIDTH{1'b0}};
  assign inst_pc    = inst_valid ? r_pc_mem[r_head[PW-1:0]]   : {ADDR_WIDTH{1'b0}};

  // Pointer, fetch PC and drop counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= {(PW+1){1'b0}};
      r_fill     <= {(PW+1){1'b0}};
      r_tail     <= {(PW+1){1'b0}};
      r_drop_cnt <= {(PW+1){1'b0}};
      r_fetch_pc <= RESET_PC;
    end else if (br_taken) begin
      r_head     <= {(PW+1){1'b0}};
      r_fill     <= {(PW+1){1'b0}};
      r_tail     <= {(PW+1){1'b0}};
      r_fetch_pc <= w_br_pc;
      // Everything still outstanding becomes stale; a response landing in
      // this cycle is one of them and is already gone.
      r_drop_cnt <= r_drop_cnt + w_unfilled - {{PW{1'b0}}, imem_rsp_valid};
    end else begin
      if (w_req_fire) begin
        r_tail     <= r_tail + {{PW{1'b0}}, 1'b1};
        r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
      end else begin
        r_tail     <= r_tail;
        r_fetch_pc <= r_fetch_pc;
      end
      if (w_rsp_drop) begin
        r_drop_cnt <= r_drop_cnt - {{PW{1'b0}}, 1'b1};
      end else begin
        r_drop_cnt <= r_drop_cnt;
      end
      if (w_rsp_write) begin
        r_fill <= r_fill + {{PW{1'b0}}, 1'b1};
      end else begin
        r_fill <= r_fill;
      end
      if (w_deq) begin
        r_head <= r_head + {{PW{1'b0}}, 1'b1};
      end else begin
        r_head <= r_head;
      end
    end
  end

  // Slot payload storage; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_pc_mem[r_tail[PW-1:0]] <= r_fetch_pc;
    end
    if (w_rsp_write) begin
      r_data_mem[r_fill[PW-1:0]] <= imem_rsp_data;
    end
  end

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] r_perf_redirect_cnt;
  logic [31:0] r_perf_bubble_cnt;

  // Saturating redirect and bubble counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_redirect_cnt <= 32'h0000_0000;
      r_perf_bubble_cnt   <= 32'h0000_0000;
    end else begin
      if (br_taken && (r_perf_redirect_cnt != 32'hFFFF_FFFF)) begin
        r_perf_redirect_cnt <= r_perf_redirect_cnt + 32'd1;
      end else begin
        r_perf_redirect_cnt <= r_perf_redirect_cnt;
      end
      if (!inst_valid && !br_taken && (r_perf_bubble_cnt != 32'hFFFF_FFFF)) begin
        r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
      end else begin
        r_perf_bubble_cnt <= r_perf_bubble_cnt;
      end
    end
  end

  assign perf_redirect_cnt = r_perf_redirect_cnt;
  assign perf_bubble_cnt   = r_perf_bubble_cnt;
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// ----------------------------------------------------------------------------
// tb_if_prefetch_queue
//   Directed bench for if_prefetch_queue. A small in-order IMEM model with a
//   programmable latency answers each request with ~addr. A second instance
//   with RESET_PC=0xFFFF_FFF8 and a 1-cycle responder covers address wrap.
// ----------------------------------------------------------------------------
module tb_if_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        br_taken;
  logic [31:0] br_target;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  logic        hi_req_valid;
  logic [31:0] hi_req_addr;
  logic        hi_rsp_valid;
  logic [31:0] hi_rsp_data;
  logic        hi_inst_valid;
  logic [31:0] hi_inst;
  logic [31:0] hi_inst_pc;

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_redirect_cnt;
  logic [31:0] perf_bubble_cnt;
  logic [31:0] hi_perf_redirect_cnt;
  logic [31:0] hi_perf_bubble_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 1;
  int reqs;
  int unsigned mcyc = 0;

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } pend_t;
  pend_t pend[$];

  if_prefetch_queue #(.RESET_PC(32'h0000_0000)) u_dut (
`ifdef IF_PREFETCH_PERF_EN
    .perf_redirect_cnt (perf_redirect_cnt),
    .perf_bubble_cnt   (perf_bubble_cnt),
`endif
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (req_valid),
    .imem_req_ready (req_ready),
    .imem_req_addr  (req_addr),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_data  (rsp_data),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  if_prefetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
`ifdef IF_PREFETCH_PERF_EN
    .perf_redirect_cnt (hi_perf_redirect_cnt),
    .perf_bubble_cnt   (hi_perf_bubble_cnt),
`endif
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (hi_req_valid),
    .imem_req_ready (1'b1),
    .imem_req_addr  (hi_req_addr),
    .imem_rsp_valid (hi_rsp_valid),
    .imem_rsp_data  (hi_rsp_data),
    .br_taken       (1'b0),
    .br_target      (32'h0000_0000),
    .stall          (1'b0),
    .inst_valid     (hi_inst_valid),
    .inst           (hi_inst),
    .inst_pc        (hi_inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // In-order IMEM model with latency 'lat'; response data is ~address.
  always @(posedge clk) begin
    rsp_valid <= 1'b0;
    if (rst) begin
      pend.delete();
    end else begin
      if (req_valid && req_ready) pend.push_back('{mcyc + lat - 1, req_addr});
      if (pend.size() > 0 && pend[0].due <= mcyc) begin
        rsp_valid <= 1'b1;
        rsp_data  <= ~pend[0].addr;
        void'(pend.pop_front());
      end
    end
    mcyc <= mcyc + 1;
  end

  // 1-cycle responder for the wrap-around instance.
  always @(posedge clk) begin
    hi_rsp_valid <= !rst && hi_req_valid;
    hi_rsp_data  <= ~hi_req_addr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0; req_ready = 1'b1;

    // ---------- reset state and test 1 / test 5 ----------
    next(); #1;
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_req_valid",  {31'b0, req_valid},  32'd0);
    chk("rst_inst",       inst,                32'h0);
    chk("rst_inst_pc",    inst_pc,             32'h0);
    next(); rst = 1'b0; #1;                                  // C0
    chk("t1_c0_req_valid", {31'b0, req_valid}, 32'd1);
    chk("t1_c0_addr",      req_addr,           32'h0);
    chk("t1_c0_inst_valid",{31'b0, inst_valid},32'd0);
    chk("t5_c0_addr",      hi_req_addr,        32'hFFFF_FFF8);
    next(); #1;                                              // C1
    chk("t1_c1_addr",       req_addr,            32'h4);
    chk("t1_c1_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("t5_c1_addr",       hi_req_addr,         32'hFFFF_FFFC);
    next(); #1;                                              // C2
    chk("t1_c2_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("t1_c2_inst_pc",    inst_pc,             32'h0);
    chk("t1_c2_inst",       inst,                32'hFFFF_FFFF);
    chk("t1_c2_addr",       req_addr,            32'h8);
    chk("t5_c2_addr",       hi_req_addr,         32'h0);
    chk("t5_c2_inst_pc",    hi_inst_pc,          32'hFFFF_FFF8);
    chk("t5_c2_inst",       hi_inst,             32'h0000_0007);
    next(); #1;                                              // C3
    chk("t1_c3_inst_pc", inst_pc,    32'h4);
    chk("t1_c3_inst",    inst,       32'hFFFF_FFFB);
    chk("t1_c3_addr",    req_addr,   32'hC);
    chk("t5_c3_inst_pc", hi_inst_pc, 32'hFFFF_FFFC);
    next(); #1;                                              // C4
    chk("t5_c4_inst_pc", hi_inst_pc, 32'h0);
    chk("t5_c4_inst",    hi_inst,    32'hFFFF_FFFF);
    chk("t1_c4_inst_pc", inst_pc,    32'h8);

    // ---------- test 2: stall from reset release ----------
    next(); rst = 1'b1; stall = 1'b1; #1;
    next(); rst = 1'b0; #1;                                  // C0
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (req_valid && req_ready) reqs++;
      next(); #1;
    end                                                      // now C10
    chk("t2_req_count",   reqs,                32'd4);
    chk("t2_inst_valid",  {31'b0, inst_valid}, 32'd1);
    chk("t2_head_pc",     inst_pc,             32'h0);
    stall = 1'b0; #1;
    chk("t2_c10_req_valid", {31'b0, req_valid}, 32'd0);
    next(); #1;                                              // C11
    chk("t2_c11_req_valid", {31'b0, req_valid}, 32'd1);
    chk("t2_c11_addr",      req_addr,           32'h10);
    chk("t2_c11_inst_pc",   inst_pc,            32'h4);

    // ---------- test 3: latency 3, redirect with 3 in flight ----------
    next(); rst = 1'b1; lat = 3; #1;
    next(); rst = 1'b0; #1;                                  // C0
    chk("t3_c0_addr", req_addr, 32'h0);
    next(); next(); next();                                  // C3
    br_taken = 1'b1; br_target = 32'h0000_0103; #1;
    chk("t3_c3_req_valid",  {31'b0, req_valid},  32'd0);
    chk("t3_c3_inst_valid", {31'b0, inst_valid}, 32'd0);
    next(); br_taken = 1'b0; #1;                             // C4
    chk("t3_c4_req_valid", {31'b0, req_valid}, 32'd1);
    chk("t3_c4_addr",      req_addr,           32'h100);
`ifdef IF_PREFETCH_PERF_EN
    chk("t3_perf_redirect", perf_redirect_cnt, 32'd1);
`endif
    next(); #1;
    chk("t3_c5_inst_valid", {31'b0, inst_valid}, 32'd0);
    next(); #1;
    chk("t3_c6_inst_valid", {31'b0, inst_valid}, 32'd0);
    next(); #1;
    chk("t3_c7_inst_valid", {31'b0, inst_valid}, 32'd0);
    next(); #1;                                              // C8
    chk("t3_c8_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("t3_c8_inst_pc",    inst_pc,             32'h100);
    chk("t3_c8_inst",       inst,                32'hFFFF_FEFF);
    next(); #1;                                              // C9
    chk("t3_c9_inst_pc", inst_pc, 32'h104);
    chk("t3_c9_inst",    inst,    32'hFFFF_FEFB);

    // ---------- test 4: redirect + response + stall in one cycle ----------
    next(); rst = 1'b1; lat = 1; #1;
    next(); rst = 1'b0; #1;                                  // C0
    next(); next();                                          // C2
    br_taken = 1'b1; stall = 1'b1; br_target = 32'h0000_0200; #1;
    chk("t4_c2_rsp_in_flight", {31'b0, rsp_valid}, 32'd1);
    chk("t4_c2_req_valid",     {31'b0, req_valid}, 32'd0);
    next(); br_taken = 1'b0; stall = 1'b0; #1;               // C3
    chk("t4_c3_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("t4_c3_addr",       req_addr,            32'h200);
    next(); #1;                                              // C4
    chk("t4_c4_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("t4_c4_addr",       req_addr,            32'h204);
    next(); #1;                                              // C5
    chk("t4_c5_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("t4_c5_inst_pc",    inst_pc,             32'h200);
    chk("t4_c5_inst",       inst,                32'hFFFF_FDFF);
    br_taken = 1'b1; br_target = 32'h0000_0300; #1;
    chk("t4_c5_br_req_valid", {31'b0, req_valid}, 32'd0);
    next(); br_taken = 1'b0; #1;                             // C6
    chk("t4_c6_addr",       req_addr,            32'h300);
    chk("t4_c6_inst_valid", {31'b0, inst_valid}, 32'd0);
`ifdef IF_PREFETCH_PERF_EN
    chk("t4_perf_redirect", perf_redirect_cnt, 32'd2);
`endif
    next(); #1;
    chk("t4_c7_inst_valid", {31'b0, inst_valid}, 32'd0);
    next(); #1;                                              // C8
    chk("t4_c8_inst_pc", inst_pc, 32'h300);
    chk("t4_c8_inst",    inst,    32'hFFFF_FCFF);

    // ---------- test 6: reset mid-stream with 2 entries queued ----------
    next(); rst = 1'b1; #1;                                  // C9
    chk("t6_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("t6_rst_req_valid",  {31'b0, req_valid},  32'd0);
    chk("t6_rst_inst_pc",    inst_pc,             32'h0);
    next(); rst = 1'b0; #1;
    chk("t6_r0_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("t6_r0_req_valid",  {31'b0, req_valid},  32'd1);
    chk("t6_r0_addr",       req_addr,            32'h0);
    next(); #1;
    chk("t6_r1_inst_valid", {31'b0, inst_valid}, 32'd0);
    next(); #1;
    chk("t6_r2_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("t6_r2_inst_pc",    inst_pc,             32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
